// File: rtl/race_ctrl_if.sv
// Signal bundle between the game/track logic (master) and the race sequencer (slave).
interface race_ctrl_if;
  logic       game_visible;
  logic       checkpoint;
  logic       finish_line;
  logic       countdown_visible;
  logic [3:0] countdown_value;
  logic       go_visible;
  logic       player_enable;
  logic       lap_timer_run;
  logic       lap_timer_clear;
  logic [3:0] lap_count;
  logic       lap_done;
  logic       race_over;

  modport master (
    output game_visible, checkpoint, finish_line,
    input  countdown_visible, countdown_value, go_visible, player_enable,
           lap_timer_run, lap_timer_clear, lap_count, lap_done, race_over
  );

  modport slave (
    input  game_visible, checkpoint, finish_line,
    output countdown_visible, countdown_value, go_visible, player_enable,
           lap_timer_run, lap_timer_clear, lap_count, lap_done, race_over
  );
endinterface

// File: rtl/race_ctrl.sv
// Race sequencer: start-light countdown, GO display, checkpoint-validated lap
// counting and race end. All outputs are registered from the next-state values.
module race_ctrl #(
  parameter int unsigned TICK_DIV   = 40_000_000,
  parameter int unsigned COUNT_FROM = 3,
  parameter int unsigned LAPS       = 3
) (
  input  logic       pclk,
  input  logic       rst_n,
  race_ctrl_if.slave bus
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    FIRST    = 4'(COUNT_FROM);
  localparam logic [3:0]    LAST_LAP = 4'(LAPS);

  typedef enum logic [2:0] {IDLE, COUNTDOWN, GO, RACING, FINISHED} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic          armed, armed_d;
  logic [3:0]    digit_d, laps_d;
  logic          tick, lap_taken;
  logic          cv_d, go_d, pe_d, run_d, clr_d, done_d, over_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      presc                 <= '0;
      armed                 <= 1'b0;
      bus.countdown_visible <= 1'b0;
      bus.countdown_value   <= '0;
      bus.go_visible        <= 1'b0;
      bus.player_enable     <= 1'b0;
      bus.lap_timer_run     <= 1'b0;
      bus.lap_timer_clear   <= 1'b0;
      bus.lap_count         <= '0;
      bus.lap_done          <= 1'b0;
      bus.race_over         <= 1'b0;
    end else begin
      state                 <= state_d;
      presc                 <= presc_d;
      armed                 <= armed_d;
      bus.countdown_visible <= cv_d;
      bus.countdown_value   <= digit_d;
      bus.go_visible        <= go_d;
      bus.player_enable     <= pe_d;
      bus.lap_timer_run     <= run_d;
      bus.lap_timer_clear   <= clr_d;
      bus.lap_count         <= laps_d;
      bus.lap_done          <= done_d;
      bus.race_over         <= over_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block, otherwise
  // paths that skip an assignment would infer a latch.
  always_comb begin
    state_d   = state;
    presc_d   = '0;
    armed_d   = armed;
    digit_d   = bus.countdown_value;
    laps_d    = bus.lap_count;
    lap_taken = 1'b0;
    tick      = (presc == TICK_MAX);

    case (state)
      IDLE: begin
        if (bus.game_visible) begin
          state_d = COUNTDOWN;
          digit_d = FIRST;
          laps_d  = '0;
          armed_d = 1'b0;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (bus.countdown_value <= 4'd1) begin
            state_d = GO;
            digit_d = '0;
          end else begin
            digit_d = bus.countdown_value - 4'd1;
          end
        end
      end
      GO, RACING: begin
        // finish_line is judged on the pre-edge armed value; a counted lap disarms.
        if (bus.finish_line && armed && (bus.lap_count < LAST_LAP)) begin
          lap_taken = 1'b1;
          laps_d    = bus.lap_count + 4'd1;
          armed_d   = 1'b0;
          if (laps_d == LAST_LAP) state_d = FINISHED;
        end else if (bus.checkpoint) begin
          armed_d = 1'b1;
        end
        if ((state == GO) && tick && (state_d == GO)) state_d = RACING;
      end
      FINISHED: ;
      default: state_d = IDLE;
    endcase

    if ((state_d == state) && ((state == COUNTDOWN) || (state == GO)))
      presc_d = tick ? '0 : presc + PW'(1);

    // Leaving the race screen wins over everything else.
    if (!bus.game_visible) begin
      state_d   = IDLE;
      presc_d   = '0;
      armed_d   = 1'b0;
      digit_d   = '0;
      laps_d    = '0;
      lap_taken = 1'b0;
    end
  end

  always_comb begin
    cv_d   = (state_d == COUNTDOWN);
    go_d   = (state_d == GO);
    pe_d   = (state_d == GO) || (state_d == RACING);
    run_d  = pe_d;
    over_d = (state_d == FINISHED);
    done_d = lap_taken;
    // The final lap keeps its time on the display, so it is not cleared.
    clr_d  = ((state == IDLE) && (state_d == COUNTDOWN)) ||
             (lap_taken && (state_d != FINISHED));
  end

endmodule
